// File: rtl/rca_sum_accum.sv
// ---------------------------------------------------------------------------
// rca_sum_accum
//   Accumulates 5-bit sums produced by an upstream ripple-carry adder into an
//   8-bit batch total. Each accepted sum is given SETTLE_CYCLES clocks to
//   ripple before it is sampled, then added into the running total. After
//   BATCH sums the total is presented with acc_valid until the consumer
//   takes it with acc_ready.
//
//   Parameters
//     SETTLE_CYCLES  ripple time before sampling, 1..15   (default 3)
//     BATCH          sums per completed total, 1..31      (default 4)
//
//   Ports
//     clk        in   1  rising-edge clock
//     rst_n      in   1  asynchronous active-low reset
//     sum_in     in   5  upstream sum, bit 4 = carry out
//     in_valid   in   1  new operand set present on sum_in
//     in_ready   out  1  ready to accept a new sum (IDLE only)
//     acc_out    out  8  running batch total
//     acc_valid  out  1  acc_out holds a completed batch (DONE only)
//     acc_ready  in   1  downstream consumes the completed total
//     count      out  5  sums accumulated in the current batch
//     ovf        out  1  sticky: batch total went past 255
//
//   Build option
//     RCA_SUM_SATURATE_EN  defined  : total clamps to 255 on overflow
//                          undefined: total wraps modulo 256 on overflow
// ---------------------------------------------------------------------------
module rca_sum_accum #(
   parameter int unsigned SETTLE_CYCLES = 3,
   parameter int unsigned BATCH         = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] sum_in,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] acc_out,
   output logic       acc_valid,
   input  logic       acc_ready,
   output logic [4:0] count,
   output logic       ovf
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      ACCUM  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [4:0] BATCH_CNT   = 5'(BATCH);

   state_t     r_state;
   logic [3:0] r_settle_cnt;
   logic [4:0] r_sample;
   logic [7:0] r_acc;
   logic [4:0] r_count;
   logic       r_ovf;
   logic       r_in_ready;
   logic       r_acc_valid;

   logic [8:0] w_sum9;
   logic [7:0] w_acc_nxt;
   logic [4:0] w_count_nxt;

   always_comb begin
      w_sum9      = {1'b0, r_acc} + {4'b0000, r_sample};
      w_count_nxt = r_count + 5'd1;
`ifdef RCA_SUM_SATURATE_EN
      w_acc_nxt   = w_sum9[8] ? 8'hFF : w_sum9[7:0];
`else
      w_acc_nxt   = w_sum9[7:0];
`endif
   end

   // in_ready / acc_valid are registered alongside the state so that each is
   // asserted exactly in IDLE / DONE respectively.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_settle_cnt <= '0;
         r_sample     <= '0;
         r_acc        <= '0;
         r_count      <= '0;
         r_ovf        <= 1'b0;
         r_in_ready   <= 1'b1;
         r_acc_valid  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_state      <= SETTLE;
                  r_settle_cnt <= SETTLE_LOAD;
                  r_in_ready   <= 1'b0;
               end
            end
            SETTLE: begin
               // sum_in is only looked at on the edge where the count expires
               if (r_settle_cnt == 4'd0) begin
                  r_sample <= sum_in;
                  r_state  <= ACCUM;
               end else begin
                  r_settle_cnt <= r_settle_cnt - 4'd1;
               end
            end
            ACCUM: begin
               r_acc   <= w_acc_nxt;
               r_count <= w_count_nxt;
               if (w_sum9[8]) r_ovf <= 1'b1;
               if (w_count_nxt == BATCH_CNT) begin
                  r_state     <= DONE;
                  r_acc_valid <= 1'b1;
               end else begin
                  r_state    <= IDLE;
                  r_in_ready <= 1'b1;
               end
            end
            DONE: begin
               if (acc_ready) begin
                  r_state     <= IDLE;
                  r_acc       <= '0;
                  r_count     <= '0;
                  r_ovf       <= 1'b0;
                  r_acc_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_acc_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign acc_out   = r_acc;
   assign acc_valid = r_acc_valid;
   assign count     = r_count;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_rca_sum_accum.sv
// ---------------------------------------------------------------------------
// tb_rca_sum_accum
//   Directed bench for rca_sum_accum. u_dut uses the default parameters,
//   u_dut16 uses BATCH=16 for the overflow scenario. Inputs are driven on
//   the falling edge and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_rca_sum_accum;

   logic       clk;
   logic       rst_n;

   logic [4:0] sum_in;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] acc_out;
   logic       acc_valid;
   logic       acc_ready;
   logic [4:0] count;
   logic       ovf;

   logic [4:0] sum_in2;
   logic       in_valid2;
   logic       in_ready2;
   logic [7:0] acc_out2;
   logic       acc_valid2;
   logic       acc_ready2;
   logic [4:0] count2;
   logic       ovf2;

   int unsigned checks;
   int unsigned errors;

   rca_sum_accum u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sum_in    (sum_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .acc_out   (acc_out),
      .acc_valid (acc_valid),
      .acc_ready (acc_ready),
      .count     (count),
      .ovf       (ovf)
   );

   rca_sum_accum #(.SETTLE_CYCLES(3), .BATCH(16)) u_dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .sum_in    (sum_in2),
      .in_valid  (in_valid2),
      .in_ready  (in_ready2),
      .acc_out   (acc_out2),
      .acc_valid (acc_valid2),
      .acc_ready (acc_ready2),
      .count     (count2),
      .ovf       (ovf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offer one sum, hold it stable, return at the falling edge after the
   // accumulate edge (N+4). low = falling-edge samples of in_ready == 0
   // among the four taken after the accepting edge N.
   task automatic send(input int unsigned inst, input logic [4:0] v,
                       output int unsigned low);
      low = 0;
      @(negedge clk);
      if (inst == 0) begin sum_in = v; in_valid = 1'b1; end
      else begin sum_in2 = v; in_valid2 = 1'b1; end
      @(negedge clk);
      in_valid  = 1'b0;
      in_valid2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (((inst == 0) ? in_ready : in_ready2) == 1'b0) low++;
         @(negedge clk);
      end
   endtask

   task automatic consume1;
      @(negedge clk);
      acc_ready = 1'b1;
      @(negedge clk);
      acc_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      checks++;
      if (acc_out !== 8'd0 || acc_valid !== 1'b0 || count !== 5'd0 ||
          ovf !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_init: acc=%0d av=%b cnt=%0d ovf=%b rdy=%b, required 0 0 0 0 1",
                  acc_out, acc_valid, count, ovf, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      int unsigned low;
      logic [4:0] vec [4];
      logic [7:0] exp_acc [4];
      vec[0] = 5'b00100; vec[1] = 5'b00000; vec[2] = 5'b00001; vec[3] = 5'b00010;
      exp_acc[0] = 8'd4; exp_acc[1] = 8'd4; exp_acc[2] = 8'd5; exp_acc[3] = 8'd7;
      for (int i = 0; i < 4; i++) begin
         send(0, vec[i], low);
         checks++;
         if (low !== 4) begin
            errors++;
            $display("FAIL basic_ready_low[%0d]: low cycles %0d, required 4", i, low);
         end
         checks++;
         if (acc_out !== exp_acc[i] || count !== 5'(i + 1)) begin
            errors++;
            $display("FAIL basic_acc[%0d]: acc=%0d cnt=%0d, required %0d %0d",
                     i, acc_out, count, exp_acc[i], i + 1);
         end
         if (i == 0) begin
            checks++;
            if (in_ready !== 1'b1 || acc_valid !== 1'b0) begin
               errors++;
               $display("FAIL basic_back_idle: rdy=%b av=%b, required 1 0", in_ready, acc_valid);
            end
         end
      end
      checks++;
      if (acc_valid !== 1'b1 || ovf !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: av=%b ovf=%b rdy=%b, required 1 0 0", acc_valid, ovf, in_ready);
      end
   endtask

   task automatic test_backpressure;
      acc_ready = 1'b0;
      in_valid  = 1'b1;
      sum_in    = 5'd3;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (acc_out !== 8'd7 || in_ready !== 1'b0 || acc_valid !== 1'b1 || count !== 5'd4) begin
            errors++;
            $display("FAIL bp_hold[%0d]: acc=%0d rdy=%b av=%b cnt=%0d, required 7 0 1 4",
                     i, acc_out, in_ready, acc_valid, count);
         end
      end
      acc_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      acc_ready = 1'b0;
      checks++;
      if (acc_valid !== 1'b0 || acc_out !== 8'd0 || count !== 5'd0 ||
          ovf !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: av=%b acc=%0d cnt=%0d ovf=%b rdy=%b, required 0 0 0 0 1",
                  acc_valid, acc_out, count, ovf, in_ready);
      end
   endtask

   // Garbage on sum_in during N..N+2, restored value present only at N+3.
   task automatic test_sample_timing;
      int unsigned low;
      @(negedge clk);
      sum_in = 5'd5; in_valid = 1'b1;
      @(negedge clk);               // after edge N
      in_valid = 1'b0; sum_in = 5'd31;
      @(negedge clk);               // after N+1
      @(negedge clk);               // after N+2
      sum_in = 5'd5;
      @(negedge clk);               // after N+3: sampled, not yet added
      checks++;
      if (acc_out !== 8'd0 || count !== 5'd0) begin
         errors++;
         $display("FAIL latency_early: acc=%0d cnt=%0d at N+3, required 0 0", acc_out, count);
      end
      @(negedge clk);               // after N+4
      checks++;
      if (acc_out !== 8'd5 || count !== 5'd1) begin
         errors++;
         $display("FAIL sample_timing: acc=%0d cnt=%0d, required 5 1", acc_out, count);
      end
      send(0, 5'd1, low);
      send(0, 5'd1, low);
      send(0, 5'd1, low);
      checks++;
      if (acc_out !== 8'd8 || count !== 5'd4 || acc_valid !== 1'b1) begin
         errors++;
         $display("FAIL timing_batch: acc=%0d cnt=%0d av=%b, required 8 4 1", acc_out, count, acc_valid);
      end
      consume1();
   endtask

   task automatic test_overflow;
      int unsigned low;
      logic [7:0] exp_final;
`ifdef RCA_SUM_SATURATE_EN
      exp_final = 8'd255;
`else
      exp_final = 8'd240;
`endif
      for (int i = 0; i < 16; i++) begin
         send(1, 5'b11111, low);
         if (i == 7) begin
            checks++;
            if (acc_out2 !== 8'd248 || ovf2 !== 1'b0) begin
               errors++;
               $display("FAIL ovf_edge_248: acc=%0d ovf=%b, required 248 0", acc_out2, ovf2);
            end
         end
         if (i == 8) begin
            checks++;
`ifdef RCA_SUM_SATURATE_EN
            if (acc_out2 !== 8'd255 || ovf2 !== 1'b1) begin
               errors++;
               $display("FAIL ovf_first: acc=%0d ovf=%b, required 255 1", acc_out2, ovf2);
            end
`else
            if (acc_out2 !== 8'd23 || ovf2 !== 1'b1) begin
               errors++;
               $display("FAIL ovf_first: acc=%0d ovf=%b, required 23 1", acc_out2, ovf2);
            end
`endif
         end
      end
      checks++;
      if (acc_out2 !== exp_final || ovf2 !== 1'b1 || count2 !== 5'd16 || acc_valid2 !== 1'b1) begin
         errors++;
         $display("FAIL ovf_final: acc=%0d ovf=%b cnt=%0d av=%b, required %0d 1 16 1",
                  acc_out2, ovf2, count2, acc_valid2, exp_final);
      end
   endtask

   // u_dut16 sits in DONE with ovf set; reset asserted between clock edges.
   task automatic test_async_reset;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (acc_out2 !== 8'd0 || acc_valid2 !== 1'b0 || count2 !== 5'd0 ||
          ovf2 !== 1'b0 || in_ready2 !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: acc=%0d av=%b cnt=%0d ovf=%b rdy=%b, required 0 0 0 0 1",
                  acc_out2, acc_valid2, count2, ovf2, in_ready2);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mid_reset;
      int unsigned low;
      send(0, 5'd1, low);
      send(0, 5'd1, low);
      @(negedge clk);
      sum_in = 5'd1; in_valid = 1'b1;
      @(negedge clk);               // third sum accepted, in SETTLE
      in_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (acc_out !== 8'd0 || count !== 5'd0 || acc_valid !== 1'b0 ||
          ovf !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: acc=%0d cnt=%0d av=%b ovf=%b rdy=%b, required 0 0 0 0 1",
                  acc_out, count, acc_valid, ovf, in_ready);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (acc_out !== 8'd0 || count !== 5'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_release: acc=%0d cnt=%0d rdy=%b, required 0 0 1",
                  acc_out, count, in_ready);
      end
      for (int i = 0; i < 4; i++) send(0, 5'b00001, low);
      checks++;
      if (acc_out !== 8'd4 || count !== 5'd4 || acc_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_batch: acc=%0d cnt=%0d av=%b, required 4 4 1",
                  acc_out, count, acc_valid);
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst_n      = 1'b1;
      sum_in     = '0;
      in_valid   = 1'b0;
      acc_ready  = 1'b0;
      sum_in2    = '0;
      in_valid2  = 1'b0;
      acc_ready2 = 1'b0;

      test_reset();
      test_basic();
      test_backpressure();
      test_sample_timing();
      test_overflow();
      test_async_reset();
      test_mid_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rca_sum_accum.md
RCA_SUM_ACCUM -- requirements
Module: rca_sum_accum

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 3, number of cycles the incoming 5-bit sum is allowed to ripple before sampling; legal range 1..15.
REQ-002 Parameter: BATCH, default 4, number of sums accumulated per result; legal range 1..31.
REQ-003 One clock; reset is asynchronous and active-low: clk input, rst_n input.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 sum_in  input  5  unsigned sum from the upstream ripple-carry adder, bit 4 = carry out.
REQ-007 in_valid  input  1  upstream asserts when sum_in belongs to a new operand set.
REQ-008 in_ready  output  1  block can accept a new sum.
REQ-009 acc_out  output  8  running batch total, registered.
REQ-010 acc_valid  output  1  acc_out holds a completed batch total.
REQ-011 acc_ready  input  1  downstream consumes the completed total.
REQ-012 count  output  5  number of sums accumulated in the current batch.
REQ-013 ovf  output  1  sticky flag: the batch total exceeded 255.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, ACCUM and DONE; in_ready SHALL be 1 only in IDLE, and acc_valid SHALL be 1 only in DONE.
REQ-015 IDLE: in_valid&in_ready SHALL move to SETTLE and load the settle counter with SETTLE_CYCLES-1.
REQ-016 SETTLE: the counter SHALL decrement each cycle; at counter==0, sum_in SHALL be registered into a sample register and the FSM SHALL move to ACCUM.
REQ-017 Upstream SHALL hold sum_in stable from acceptance until sampling; the block SHALL NOT sample at any other time.
REQ-018 ACCUM: the FSM SHALL compute acc_out+sample at 9 bits and update acc_out, and SHALL increment count; if the new count==BATCH it SHALL move to DONE, otherwise to IDLE.
REQ-019 Latency: for a sum accepted at edge N, sampling SHALL occur at edge N+SETTLE_CYCLES and acc_out SHALL update at edge N+SETTLE_CYCLES+1.
REQ-020 DONE: acc_out, count and ovf SHALL hold while acc_ready=0; in_valid SHALL be ignored.
REQ-021 DONE with acc_ready=1: at the next edge acc_out, count and ovf SHALL clear to 0 and the FSM SHALL move to IDLE, so acc_valid drops one cycle after the handshake.
REQ-022 If the 9-bit sum exceeds 255, ovf SHALL set and remain set until the batch is consumed or reset occurs; the acc_out result follows REQ-027 and REQ-028.
REQ-023 in_valid asserted outside IDLE SHALL have no effect.

Reset
REQ-024 rst_n=0 SHALL, without waiting for clk, force state IDLE and acc_out=0, acc_valid=0, count=0, ovf=0, in_ready=1, and clear the settle counter and sample register.
REQ-025 Reset in any state, including mid-SETTLE or DONE, SHALL discard the partial batch; after release, the first accepted sum starts a new batch at count=0.
REQ-026 Reset release SHALL take effect on the first clk edge at which rst_n=1.

Configuration
REQ-027 Macro RCA_SUM_SATURATE_EN defined: on overflow acc_out SHALL clamp to 255 and ovf SHALL set.
REQ-028 Macro RCA_SUM_SATURATE_EN undefined: on overflow acc_out SHALL wrap modulo 256 and ovf SHALL set.

Verification
REQ-029 Reset check: rst_n=0 asynchronously mid-cycle -> acc_out=0, acc_valid=0, count=0, ovf=0, in_ready=1 immediately.
REQ-030 Defaults, sums 00100, 00000, 00001, 00010 each offered with in_valid -> in_ready low 4 cycles per sum, acc_out=7, count=4, acc_valid=1, ovf=0.
REQ-031 Timing check: sum_in changed to a garbage value 1 cycle after acceptance, then restored before the sampling edge (edge N+3) -> the sample equals the restored value, proving sampling occurs only at N+3.
REQ-032 Backpressure: acc_ready=0 for 5 cycles in DONE while in_valid=1 -> acc_out=7 held and in_ready=0; acc_ready=1 -> next cycle acc_valid=0, acc_out=0, count=0.
REQ-033 Overflow: BATCH=16, sum_in=11111 x16 -> without the macro acc_out=240, ovf=1; with RCA_SUM_SATURATE_EN acc_out=255, ovf=1.
REQ-034 Mid-operation reset: rst_n pulsed low during SETTLE of the 3rd sum -> outputs zero; next 4 sums of 00001 -> acc_out=4, count=4.
